drv_cmd_master: RTL and testbench

DRV_CMD_MASTER -- requirements
Module: drv_cmd_master

---
 rtl/drv_cmd_master_pkg.sv | 32 +++
 rtl/cmd_if.sv | 10 +
 rtl/cmd_timeout.sv | 29 ++
 rtl/drv_cmd_master.sv | 152 +++++++++++++++
 tb/tb_drv_cmd_master.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/drv_cmd_master_pkg.sv
// Shared driver package: settings record, error codes, host register map and FSM states.
package drv_cmd_master_pkg;

    localparam int unsigned FreqW  = 32;
    localparam int unsigned DutyW  = 16;
    localparam int unsigned PhaseW = 16;

    typedef struct packed {
        logic [FreqW-1:0]  freq;
        logic [DutyW-1:0]  duty;
        logic [PhaseW-1:0] phase;
    } settings_t;

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrRange   = 2'd1,
        ErrTimeout = 2'd2
    } err_code_e;

    localparam logic [1:0] AddrFreq  = 2'd0;
    localparam logic [1:0] AddrDuty  = 2'd1;
    localparam logic [1:0] AddrPhase = 2'd2;
    localparam logic [1:0] AddrRsvd  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StReq,
        StWait
    } state_e;

endpackage

// File: rtl/cmd_if.sv
// Handshake between the command master and the output driver.
interface cmd_if;

    logic apply;
    logic apply_ok;

    modport out (output apply, input apply_ok);
    modport drv (input apply, output apply_ok);

endinterface

// File: rtl/cmd_timeout.sv
// Saturating cycle counter that flags when the driver has not acknowledged in time.
module cmd_timeout #(
    parameter int unsigned LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CntW-1:0] cnt_q;

    assign expired = (cnt_q == CntW'(LIMIT));

    // Count enabled cycles, stopping at the limit until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/drv_cmd_master.sv
// Host-facing command master: shadows freq/duty/phase writes, validates them on commit and
// hands them to the driver through an apply / apply_ok handshake with timeout.
module drv_cmd_master
    import drv_cmd_master_pkg::*;
#(
    parameter int unsigned MIN_FREQ_HZ   = 1000,
    parameter int unsigned MAX_FREQ_HZ   = 500000,
    parameter int unsigned DUTY_SCALE    = 100,
    parameter int unsigned PHASE_SCALE   = 360,
    parameter int unsigned TIMEOUT_TICKS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        commit,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    cmd_if.out          cmd,
    output settings_t   settings,
    output logic        recalc_ph_dc
);

    localparam settings_t SettingsRst = '{freq: FreqW'(MIN_FREQ_HZ), duty: '0, phase: '0};

    state_e    state_q, state_d;
    settings_t shadow_q, shadow_d;
    settings_t active_q, active_d;
    settings_t settings_q, settings_d;
    err_code_e err_code_q, err_code_d;
    logic      done_q, done_d;
    logic      err_q, err_d;
    logic      apply_q, apply_d;
    logic      recalc_q, recalc_d;
    logic      tmo_clear;
    logic      tmo_expired;
    logic      shadow_valid;

    assign shadow_valid = (shadow_q.freq >= MIN_FREQ_HZ) && (shadow_q.freq <= MAX_FREQ_HZ) &&
                          (32'(shadow_q.duty) <= DUTY_SCALE) &&
                          (32'(shadow_q.phase) <= PHASE_SCALE - 1);

    cmd_timeout #(
        .LIMIT (TIMEOUT_TICKS)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (state_q == StWait),
        .expired (tmo_expired)
    );

    // Next-state and next-output decode; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        settings_d = settings_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        apply_d    = 1'b0;
        recalc_d   = 1'b0;
        tmo_clear  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wr_en) begin
                    unique case (wr_addr)
                        AddrFreq:  shadow_d.freq  = wr_data[FreqW-1:0];
                        AddrDuty:  shadow_d.duty  = wr_data[DutyW-1:0];
                        AddrPhase: shadow_d.phase = wr_data[PhaseW-1:0];
                        default:   ;
                    endcase
                end
                if (commit) begin
                    state_d    = StCheck;
                    err_code_d = ErrNone;
                end
            end
            StCheck: begin
                if (!shadow_valid) begin
                    state_d    = StIdle;
                    err_d      = 1'b1;
                    err_code_d = ErrRange;
                end else if (shadow_q == active_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d    = StReq;
                    settings_d = shadow_q;
                    // A frequency change needs a full reprogram; otherwise only phase/duty.
                    apply_d    = (shadow_q.freq != active_q.freq);
                    recalc_d   = (shadow_q.freq == active_q.freq);
                end
            end
            StReq: begin
                state_d   = StWait;
                tmo_clear = 1'b1;
            end
            StWait: begin
                // Acknowledge wins over a simultaneous timeout.
                if (cmd.apply_ok) begin
                    state_d  = StIdle;
                    active_d = settings_q;
                    done_d   = 1'b1;
                end else if (tmo_expired) begin
                    state_d    = StIdle;
                    settings_d = active_q;
                    err_d      = 1'b1;
                    err_code_d = ErrTimeout;
                end
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shadow_q   <= SettingsRst;
            active_q   <= SettingsRst;
            settings_q <= SettingsRst;
            err_code_q <= ErrNone;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            apply_q    <= 1'b0;
            recalc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            settings_q <= settings_d;
            err_code_q <= err_code_d;
            done_q     <= done_d;
            err_q      <= err_d;
            apply_q    <= apply_d;
            recalc_q   <= recalc_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign cmd.apply    = apply_q;
    assign settings     = settings_q;
    assign recalc_ph_dc = recalc_q;

endmodule

// File: tb/tb_drv_cmd_master.sv
// Directed plus randomized bench for drv_cmd_master against a transaction-level model.
module tb_drv_cmd_master;
    import drv_cmd_master_pkg::*;

    localparam int unsigned MinF   = 1000;
    localparam int unsigned MaxF   = 500000;
    localparam int unsigned DutyS  = 100;
    localparam int unsigned PhaseS = 360;
    localparam int unsigned Tmo    = 16;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        commit;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    settings_t   settings;
    logic        recalc_ph_dc;

    cmd_if cmd_bus ();

    drv_cmd_master #(
        .MIN_FREQ_HZ   (MinF),
        .MAX_FREQ_HZ   (MaxF),
        .DUTY_SCALE    (DutyS),
        .PHASE_SCALE   (PhaseS),
        .TIMEOUT_TICKS (Tmo)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .commit       (commit),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .cmd          (cmd_bus),
        .settings     (settings),
        .recalc_ph_dc (recalc_ph_dc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model of the host-visible register state.
    settings_t m_shadow, m_active, m_out;
    logic [1:0] m_code;

    // Responder controls.
    bit resp_on    = 1'b0;
    int resp_delay = 1;
    bit stray_req  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic settings_t reset_val();
        settings_t r;
        r.freq  = MinF;
        r.duty  = '0;
        r.phase = '0;
        return r;
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0:    m_shadow.freq  = d;
            2'd1:    m_shadow.duty  = d[15:0];
            2'd2:    m_shadow.phase = d[15:0];
            default: ;
        endcase
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(a, d);
    endtask

    // Driver-side responder: acknowledges apply/recalc after resp_delay cycles when enabled.
    initial begin
        cmd_bus.apply_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (stray_req) begin
                stray_req = 1'b0;
                cmd_bus.apply_ok = 1'b1;
                @(negedge clk);
                cmd_bus.apply_ok = 1'b0;
            end else if ((cmd_bus.apply || recalc_ph_dc) && resp_on) begin
                repeat (resp_delay) @(negedge clk);
                cmd_bus.apply_ok = 1'b1;
                @(negedge clk);
                cmd_bus.apply_ok = 1'b0;
            end
        end
    end

    // One commit transaction checked against the model; optional write in the commit cycle
    // and optional write+commit injection while busy.
    task automatic run_commit(input string tag, input bit ww, input logic [1:0] wa,
                              input logic [31:0] wd, input bit respond, input int delay,
                              input bit inject);
        bit valid, changed, fchg, success, fin;
        int n, exp_n, extra;
        if (ww) model_write(wa, wd);
        valid   = (m_shadow.freq >= MinF) && (m_shadow.freq <= MaxF) &&
                  (m_shadow.duty <= DutyS) && (m_shadow.phase <= PhaseS - 1);
        changed = (m_shadow != m_active);
        fchg    = (m_shadow.freq != m_active.freq);
        resp_on = respond; resp_delay = delay;
        commit = 1'b1;
        if (ww) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
        tick();
        commit = 1'b0; wr_en = 1'b0;
        m_code = 2'd0;
        check({tag, ".busy1"}, busy, 1'b1);
        check({tag, ".code1"}, err_code, 2'd0);
        tick();
        if (!valid) begin
            check({tag, ".rerr"}, err, 1'b1);
            check({tag, ".rcode"}, err_code, 2'd1);
            check({tag, ".rapply"}, {cmd_bus.apply, recalc_ph_dc, done}, 3'b000);
            check({tag, ".rset"}, settings, m_out);
            m_code = 2'd1;
            tick();
            check({tag, ".rafter"}, {err, busy, err_code}, {2'b00, 2'd1});
        end else if (!changed) begin
            check({tag, ".udone"}, {done, err, busy, cmd_bus.apply, recalc_ph_dc}, 5'b10000);
            tick();
            check({tag, ".uafter"}, done, 1'b0);
        end else begin
            m_out = m_shadow;
            check({tag, ".apply"}, cmd_bus.apply, fchg);
            check({tag, ".recalc"}, recalc_ph_dc, !fchg);
            check({tag, ".set"}, settings, m_out);
            check({tag, ".busy2"}, {busy, done}, 2'b10);
            success = respond && (delay <= Tmo + 1);
            exp_n   = success ? 3 + delay : 4 + Tmo;
            n = 2; fin = 1'b0; extra = 0;
            while (!fin && n < 60) begin
                tick();
                n++;
                if (inject && n == 5) begin
                    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 32'd12345; commit = 1'b1;
                end else begin
                    wr_en = 1'b0; commit = 1'b0;
                end
                if (done || err) fin = 1'b1;
                else if (cmd_bus.apply || recalc_ph_dc) extra++;
            end
            wr_en = 1'b0; commit = 1'b0;
            check({tag, ".lat"}, n, exp_n);
            check({tag, ".extra"}, extra, 0);
            if (success) begin
                m_active = m_out;
                check({tag, ".ok"}, {done, err, busy, err_code}, {3'b100, 2'd0});
            end else begin
                m_out  = m_active;
                m_code = 2'd2;
                check({tag, ".tmo"}, {done, err, busy, err_code}, {3'b010, 2'd2});
            end
            check({tag, ".set2"}, settings, m_out);
            tick();
            check({tag, ".pulse"}, {done, err}, 2'b00);
        end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
        m_shadow = reset_val(); m_active = reset_val(); m_out = reset_val(); m_code = 2'd0;
        tick();
        check("rst.ctl", {busy, done, err, err_code, cmd_bus.apply, recalc_ph_dc}, 7'd0);
        check("rst.set", settings, reset_val());
        tick();
        rst = 1'b0;
        tick();

        wr(2'd0, 32'd20000);
        run_commit("freq", 1'b0, 2'd0, 0, 1'b1, 10, 1'b0);
        wr(2'd1, 32'd30);
        run_commit("duty", 1'b0, 2'd0, 0, 1'b1, 10, 1'b0);
        wr(2'd0, 32'd600000);
        run_commit("range", 1'b0, 2'd0, 0, 1'b1, 10, 1'b0);
        tick();
        check("range.hold", err_code, 2'd1);
        run_commit("wc_max", 1'b1, 2'd0, MaxF, 1'b1, 1, 1'b0);
        run_commit("fmin_m1", 1'b1, 2'd0, MinF - 1, 1'b1, 1, 1'b0);
        run_commit("fmin", 1'b1, 2'd0, MinF, 1'b1, 3, 1'b0);
        run_commit("dmax", 1'b1, 2'd1, DutyS, 1'b1, 2, 1'b0);
        run_commit("dmax_p1", 1'b1, 2'd1, DutyS + 1, 1'b1, 2, 1'b0);
        run_commit("dtrunc", 1'b1, 2'd1, 32'h0001_0014, 1'b1, 2, 1'b0);
        run_commit("pmax", 1'b1, 2'd2, PhaseS - 1, 1'b1, 2, 1'b0);
        run_commit("pmax_p1", 1'b1, 2'd2, PhaseS, 1'b1, 2, 1'b0);
        wr(2'd2, 32'd90);
        run_commit("timeout", 1'b0, 2'd0, 0, 1'b0, 0, 1'b0);
        run_commit("tmo_edge", 1'b0, 2'd0, 0, 1'b1, Tmo + 1, 1'b0);

        stray_req = 1'b1;
        cnt = 0;
        repeat (4) begin tick(); cnt += int'(done) + int'(busy) + int'(err); end
        check("stray", cnt, 0);

        wr(2'd1, 32'd50);
        run_commit("busy_inj", 1'b0, 2'd0, 0, 1'b1, 10, 1'b1);
        run_commit("post_inj", 1'b0, 2'd0, 0, 1'b1, 1, 1'b0);
        wr(2'd3, 32'd777);
        run_commit("addr3", 1'b0, 2'd0, 0, 1'b1, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  a;
            logic [31:0] d;
            int          sel;
            repeat ($urandom_range(1, 2)) begin
                a = 2'($urandom_range(0, 3));
                sel = $urandom_range(0, 7);
                case (a)
                    2'd0: case (sel)
                        0: d = MinF - 1;
                        1: d = MinF;
                        2: d = MaxF;
                        3: d = MaxF + 1;
                        4: d = $urandom();
                        default: d = $urandom_range(MinF, MaxF);
                    endcase
                    2'd1: d = (sel == 0) ? $urandom() : $urandom_range(0, DutyS + 3);
                    2'd2: d = (sel == 0) ? $urandom() : $urandom_range(0, PhaseS + 2);
                    default: d = $urandom();
                endcase
                wr(a, d);
            end
            if ($urandom_range(0, 5) == 0)
                run_commit("rnd", 1'b0, 2'd0, 0, 1'b0, 0, 1'b0);
            else
                run_commit("rnd", 1'b1, 2'd1, $urandom_range(0, DutyS), 1'b1,
                           $urandom_range(1, Tmo + 1), 1'b0);
        end

        // Abort a transaction in WAIT with reset.
        wr(2'd1, (m_active.duty == 16'd5) ? 32'd6 : 32'd5);
        wr(2'd0, 32'd123456);
        resp_on = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (4) tick();
        check("wait.busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("arst.ctl", {busy, done, err, err_code, cmd_bus.apply, recalc_ph_dc}, 7'd0);
        check("arst.set", settings, reset_val());
        rst = 1'b0;
        m_shadow = reset_val(); m_active = reset_val(); m_out = reset_val();
        cnt = 0;
        repeat (20) begin tick(); cnt += int'(done) + int'(err) + int'(busy); end
        check("arst.quiet", cnt, 0);
        run_commit("post_rst", 1'b0, 2'd0, 0, 1'b1, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
